// File: rtl/dm_access_arbiter.sv
// Data-memory arbiter: CPU M-stage port (C) vs word-only loader/DMA port (D).
// Optional write trace compiled in with `define DM_ARB_TRACE_EN.
module dm_access_arbiter #(
  parameter int DEPTH_WORDS = 3072,
  parameter int MAX_WAIT    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           c_req,
  input  logic                           c_we,
  input  logic [2:0]                     c_op,
  input  logic [31:0]                    c_addr,
  input  logic [31:0]                    c_wdata,
  input  logic [31:0]                    c_pc,
  output logic                           c_ready,
  output logic                           c_stall,
  output logic                           c_rvalid,
  output logic [31:0]                    c_rdata,
  output logic                           c_err,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [31:0]                    d_addr,
  input  logic [31:0]                    d_wdata,
  output logic                           d_ready,
  output logic                           d_rvalid,
  output logic [31:0]                    d_rdata,
  output logic                           d_err,
  output logic                           m_en,
  output logic                           m_we,
  output logic [3:0]                     m_be,
  output logic [$clog2(DEPTH_WORDS)-1:0] m_addr,
  output logic [31:0]                    m_wdata,
  input  logic [31:0]                    m_rdata
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  // Access size codes (low two bits of c_op; bit 2 marks a load)
  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_W:    misaligned = (lane != 2'b00);
      SZ_H:    misaligned = lane[0];
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic out_of_range(input logic [29:0] word_idx);
    out_of_range = (word_idx >= 30'(DEPTH_WORDS));
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_W:    byte_en = 4'b1111;
      SZ_H:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_B:    byte_en = 4'b0001 << lane;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      SZ_H:    lane_rep = {w[15:0], w[15:0]};
      SZ_B:    lane_rep = {4{w[7:0]}};
      default: lane_rep = w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic signed [15:0] h;
    logic signed [7:0]  b;
    logic signed [31:0] r;
    h = lane[1] ? w[31:16] : w[15:0];
    b = w[8*lane +: 8];
    case (sz)
      SZ_H:    r = h;
      SZ_B:    r = b;
      default: r = w;
    endcase
    load_ext = r;
  endfunction

  // ---- p0: request decode, grant and memory drive (combinational) ----
  logic [WCW-1:0] wait_cnt;
  logic           grant_c, grant_d;
  logic           c_bad_p0, d_bad_p0;
  logic           vld_p0, err_p0, we_p0;
  logic [1:0]     sz_p0;
  logic [31:0]    addr_p0, wdata_p0;

  assign grant_d = ~reset & d_req & (~c_req | (wait_cnt == WAIT_SAT));
  assign grant_c = ~reset & c_req & ~grant_d;
  assign c_ready = grant_c;
  assign d_ready = grant_d;
  assign c_stall = ~reset & c_req & ~c_ready;

  // A load op must come with c_we low and a store op with c_we high
  assign c_bad_p0 = (c_op[1:0] == 2'b11) | (c_op[2] == c_we) |
                    misaligned(c_op[1:0], c_addr[1:0]) | out_of_range(c_addr[31:2]);
  assign d_bad_p0 = (d_addr[1:0] != 2'b00) | out_of_range(d_addr[31:2]);

  assign vld_p0   = c_ready | d_ready;
  assign err_p0   = d_ready ? d_bad_p0 : c_bad_p0;
  assign we_p0    = d_ready ? d_we     : c_we;
  assign sz_p0    = d_ready ? SZ_W     : c_op[1:0];
  assign addr_p0  = d_ready ? d_addr   : c_addr;
  assign wdata_p0 = d_ready ? d_wdata  : c_wdata;

  assign m_en    = vld_p0 & ~err_p0;
  assign m_we    = m_en & we_p0;
  assign m_be    = m_en ? byte_en(sz_p0, addr_p0[1:0]) : 4'b0000;
  assign m_addr  = m_en ? addr_p0[AW+1:2] : '0;
  assign m_wdata = m_we ? lane_rep(sz_p0, wdata_p0) : 32'h0;

  always_ff @(posedge clk) begin
    if (reset || !d_req || d_ready) wait_cnt <= '0;
    else if (wait_cnt != WAIT_SAT)  wait_cnt <= wait_cnt + WCW'(1);
  end

  // ---- p1: pending response, one cycle after accept ----
  logic       vld_p1, port_d_p1, err_p1, rd_p1;
  logic [1:0] sz_p1, lane_p1;

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      port_d_p1 <= d_ready;
      err_p1    <= err_p0;
      rd_p1     <= ~we_p0;
      sz_p1     <= sz_p0;
      lane_p1   <= addr_p0[1:0];
    end
  end

  // Gating with reset drops a response that falls due while reset is held
  logic rsp_p1;
  assign rsp_p1   = vld_p1 & ~reset;
  assign c_rvalid = rsp_p1 & ~port_d_p1;
  assign d_rvalid = rsp_p1 & port_d_p1;
  assign c_err    = c_rvalid & err_p1;
  assign d_err    = d_rvalid & err_p1;
  assign c_rdata  = (c_rvalid & ~err_p1 & rd_p1) ? load_ext(sz_p1, lane_p1, m_rdata) : 32'h0;
  assign d_rdata  = (d_rvalid & ~err_p1 & rd_p1) ? m_rdata : 32'h0;

  logic unused_pc;
  assign unused_pc = ^c_pc;

`ifdef DM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (m_we)
      $display("%d@%h: *%h <= %h", $time, d_ready ? 32'h0 : c_pc, {addr_p0[31:2], 2'b00},
               m_wdata & {{8{m_be[3]}}, {8{m_be[2]}}, {8{m_be[1]}}, {8{m_be[0]}}});
  end
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Table-driven bench for dm_access_arbiter with a response scoreboard and a memory model.
module tb_dm_access_arbiter;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;
  logic c_req, c_we, c_ready, c_stall, c_rvalid, c_err;
  logic [2:0] c_op;
  logic [31:0] c_addr, c_wdata, c_pc, c_rdata;
  logic d_req, d_we, d_ready, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic m_en, m_we;
  logic [3:0] m_be;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  dm_access_arbiter #(.DEPTH_WORDS(3072), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata), .c_pc(c_pc),
    .c_ready(c_ready), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Synchronous single-port memory with byte enables
  logic [31:0] mem [0:3071];
  initial begin
    for (int i = 0; i < 3072; i++) mem[i] = 32'h0;
    m_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (m_en && (int'(m_addr) < 3072)) begin
      if (m_we) begin
        for (int i = 0; i < 4; i++)
          if (m_be[i]) mem[m_addr][8*i +: 8] <= m_wdata[8*i +: 8];
      end else begin
        m_rdata <= mem[m_addr];
      end
    end
  end

  typedef struct {
    string       nm;
    bit          c_req, c_we;
    logic [2:0]  c_op;
    logic [31:0] c_addr, c_wdata;
    bit          d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    bit          exp_cr, exp_dr, exp_men, exp_mwe;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr, exp_mwdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          port_d;
    bit          err;
    logic [31:0] rdata;
    int          due;
    string       nm;
  } rsp_t;

  rsp_t sbq[$];
  vec_t tbl[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t idle_vec(input string nm);
    vec_t v;
    v.nm = nm;
    v.c_req = 0; v.c_we = 0; v.c_op = 3'b000; v.c_addr = 0; v.c_wdata = 0;
    v.d_req = 0; v.d_we = 0; v.d_addr = 0; v.d_wdata = 0;
    v.exp_cr = 0; v.exp_dr = 0; v.exp_men = 0; v.exp_mwe = 0;
    v.exp_be = 0; v.exp_maddr = 0; v.exp_mwdata = 0; v.exp_err = 0; v.exp_rdata = 0;
    return v;
  endfunction

  function automatic vec_t mkc(input string nm, input bit we, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata, input bit men,
                               input logic [3:0] be, input logic [31:0] mwdata, input bit err,
                               input logic [31:0] rdata);
    vec_t v = idle_vec(nm);
    v.c_req = 1; v.c_we = we; v.c_op = op; v.c_addr = addr; v.c_wdata = wdata;
    v.exp_cr = 1; v.exp_men = men; v.exp_mwe = men & we; v.exp_be = be;
    v.exp_maddr = addr >> 2; v.exp_mwdata = mwdata; v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  function automatic vec_t mkd(input string nm, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit men, input bit err,
                               input logic [31:0] rdata);
    vec_t v = idle_vec(nm);
    v.d_req = 1; v.d_we = we; v.d_addr = addr; v.d_wdata = wdata;
    v.exp_dr = 1; v.exp_men = men; v.exp_mwe = men & we; v.exp_be = 4'hF;
    v.exp_maddr = addr >> 2; v.exp_mwdata = wdata; v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  task automatic check_resp(input string tag);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      rsp_t e = sbq.pop_front();
      chk({e.nm, ".c_rvalid"}, c_rvalid, !e.port_d);
      chk({e.nm, ".d_rvalid"}, d_rvalid, e.port_d);
      if (e.port_d) begin
        chk({e.nm, ".d_err"}, d_err, e.err);
        chk({e.nm, ".d_rdata"}, d_rdata, e.rdata);
      end else begin
        chk({e.nm, ".c_err"}, c_err, e.err);
        chk({e.nm, ".c_rdata"}, c_rdata, e.rdata);
      end
    end else begin
      chk({tag, ".no_c_rvalid"}, c_rvalid, 0);
      chk({tag, ".no_d_rvalid"}, d_rvalid, 0);
    end
  endtask

  // Called just after a rising edge; returns just after the next rising edge
  task automatic apply(input vec_t v);
    c_req = v.c_req; c_we = v.c_we; c_op = v.c_op; c_addr = v.c_addr; c_wdata = v.c_wdata;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    c_pc = 32'h1000 + 32'(cyc);
    @(negedge clk);
    check_resp(v.nm);
    chk({v.nm, ".c_ready"}, c_ready, v.exp_cr);
    chk({v.nm, ".d_ready"}, d_ready, v.exp_dr);
    chk({v.nm, ".c_stall"}, c_stall, v.c_req & ~v.exp_cr);
    chk({v.nm, ".m_en"}, m_en, v.exp_men);
    if (v.exp_men) begin
      chk({v.nm, ".m_we"}, m_we, v.exp_mwe);
      chk({v.nm, ".m_addr"}, 32'(m_addr), v.exp_maddr);
      if (v.exp_mwe) begin
        chk({v.nm, ".m_be"}, 32'(m_be), 32'(v.exp_be));
        chk({v.nm, ".m_wdata"}, m_wdata, v.exp_mwdata);
      end
    end
    if (v.exp_cr || v.exp_dr)
      sbq.push_back('{port_d: v.exp_dr, err: v.exp_err, rdata: v.exp_rdata, due: cyc + 1, nm: v.nm});
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".c_ready"}, c_ready, 0);   chk({tag, ".c_stall"}, c_stall, 0);
    chk({tag, ".c_rvalid"}, c_rvalid, 0); chk({tag, ".c_rdata"}, c_rdata, 0);
    chk({tag, ".c_err"}, c_err, 0);       chk({tag, ".d_ready"}, d_ready, 0);
    chk({tag, ".d_rvalid"}, d_rvalid, 0); chk({tag, ".d_rdata"}, d_rdata, 0);
    chk({tag, ".d_err"}, d_err, 0);       chk({tag, ".m_en"}, m_en, 0);
    chk({tag, ".m_we"}, m_we, 0);         chk({tag, ".m_be"}, 32'(m_be), 0);
    chk({tag, ".m_addr"}, 32'(m_addr), 0); chk({tag, ".m_wdata"}, m_wdata, 0);
  endtask

  function automatic vec_t both_vec(input string nm, input bit d_wins);
    vec_t v = idle_vec(nm);
    v.c_req = 1; v.c_we = 0; v.c_op = 3'b100; v.c_addr = 32'h40;
    v.d_req = 1; v.d_we = 0; v.d_addr = 32'h40;
    v.exp_cr = !d_wins; v.exp_dr = d_wins; v.exp_men = 1; v.exp_mwe = 0;
    v.exp_maddr = 32'h10; v.exp_rdata = 32'h12345678;
    return v;
  endfunction

  initial begin
    // Reset with both requesters active: every output must stay 0
    reset = 1;
    c_req = 1; c_we = 1; c_op = 3'b000; c_addr = 32'h10; c_wdata = 32'h55; c_pc = 0;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h66;
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    @(posedge clk);
    #1;
    reset = 0;

    tbl.push_back(mkc("sw10",   1, 3'b000, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mkc("lw10",   0, 3'b100, 32'h10, 0, 1, 0, 0, 0, 32'hDEADBEEF));
    tbl.push_back(mkc("sb13",   1, 3'b010, 32'h13, 32'h80, 1, 4'b1000, 32'h80808080, 0, 0));
    tbl.push_back(mkc("lb13",   0, 3'b110, 32'h13, 0, 1, 0, 0, 0, 32'hFFFFFF80));
    tbl.push_back(mkc("sh12",   1, 3'b001, 32'h12, 32'h7FFF, 1, 4'b1100, 32'h7FFF7FFF, 0, 0));
    tbl.push_back(mkc("lh12",   0, 3'b101, 32'h12, 0, 1, 0, 0, 0, 32'h00007FFF));
    tbl.push_back(mkc("lh10",   0, 3'b101, 32'h10, 0, 1, 0, 0, 0, 32'hFFFFBEEF));
    tbl.push_back(mkc("lb11",   0, 3'b110, 32'h11, 0, 1, 0, 0, 0, 32'hFFFFFFBE));
    tbl.push_back(mkc("lw6",    0, 3'b100, 32'h6, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("sh5",    1, 3'b001, 32'h5, 32'h1, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("lh13",   0, 3'b101, 32'h13, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("sw3072", 1, 3'b000, 32'h3000, 32'h1, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("lw3071", 0, 3'b100, 32'h2FFC, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mkc("lwhigh", 0, 3'b100, 32'h80000010, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("op011",  1, 3'b011, 32'h0, 32'h1, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("op111",  0, 3'b111, 32'h0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("lw_we1", 1, 3'b100, 32'h0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("sw_we0", 0, 3'b000, 32'h0, 32'h1, 0, 0, 0, 1, 0));
    tbl.push_back(mkc("sb0",    1, 3'b010, 32'h0, 32'h123456A5, 1, 4'b0001, 32'hA5A5A5A5, 0, 0));
    tbl.push_back(mkc("sh0",    1, 3'b001, 32'h0, 32'hABCD1234, 1, 4'b0011, 32'h12341234, 0, 0));
    tbl.push_back(mkc("lw0",    0, 3'b100, 32'h0, 0, 1, 0, 0, 0, 32'h00001234));
    tbl.push_back(mkd("dwr40",  1, 32'h40, 32'h12345678, 1, 0, 0));
    tbl.push_back(mkc("lb41",   0, 3'b110, 32'h41, 0, 1, 0, 0, 0, 32'h00000056));
    tbl.push_back(mkc("lb42",   0, 3'b110, 32'h42, 0, 1, 0, 0, 0, 32'h00000034));
    tbl.push_back(mkd("drd40",  0, 32'h40, 0, 1, 0, 32'h12345678));
    tbl.push_back(mkd("drd42",  0, 32'h42, 0, 0, 1, 0));
    tbl.push_back(mkd("dwr3072", 1, 32'h3000, 32'h1, 0, 1, 0));
    tbl.push_back(idle_vec("idle"));

    foreach (tbl[i]) apply(tbl[i]);

    // Both held: C wins four cycles, D the fifth, then the pattern repeats
    for (int i = 0; i < 10; i++) apply(both_vec($sformatf("starve%0d", i), (i % 5) == 4));
    apply(idle_vec("idle2"));

    // Reset in the cycle after an accepted lw drops its response
    c_req = 1; c_we = 0; c_op = 3'b100; c_addr = 32'h40; d_req = 0;
    @(negedge clk);
    chk("rst_lw.c_ready", c_ready, 1);
    @(posedge clk);
    #1;
    reset = 1; d_req = 1; d_we = 0; d_addr = 32'h40;
    @(negedge clk);
    check_all_zero("rst_drop");
    @(posedge clk);
    #1;
    reset = 0;
    // Counter restarts from 0 after reset
    for (int i = 0; i < 5; i++) apply(both_vec($sformatf("post_rst%0d", i), i == 4));
    apply(idle_vec("idle3"));
    apply(idle_vec("idle4"));

    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
Arbitrates the single-port data memory between two requesters: the CPU M stage (port C, full sw/sh/sb/lw/lh/lb) and a word-only loader/DMA port (port D).
- Generates the word index, byte enables and lane-replicated write data for the memory.
- Returns sign-extended load data one cycle after grant.
- Checks alignment and range, and enforces bounded starvation for port D.
- Sits between the M-stage pipeline register and the memory array; drives the CPU stall.

Parameters:
DEPTH_WORDS, 3072, memory depth in 32-bit words; word index width is clog2(DEPTH_WORDS)
MAX_WAIT, 4, maximum consecutive cycles port D may wait while port C is granted

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
c_req  in  1  CPU access request
c_we  in  1  CPU write (store) when 1, load when 0
c_op  in  3  000 sw, 001 sh, 010 sb, 100 lw, 101 lh, 110 lb; other codes illegal
c_addr  in  32  CPU byte address
c_wdata  in  32  CPU store data, low-aligned
c_pc  in  32  PC of the M-stage instruction (trace only)
c_ready  out  1  CPU request accepted this cycle
c_stall  out  1  c_req & ~c_ready
c_rvalid  out  1  CPU response valid (loads and stores)
c_rdata  out  32  extended load data; 0 for stores and errors
c_err  out  1  with c_rvalid: misaligned, out of range or illegal op
d_req  in  1  DMA word request
d_we  in  1  DMA write
d_addr  in  32  DMA byte address; must be word aligned
d_wdata  in  32  DMA write word
d_ready  out  1  DMA request accepted this cycle
d_rvalid  out  1  DMA response valid
d_rdata  out  32  DMA read word
d_err  out  1  with d_rvalid: misaligned or out of range
m_en  out  1  memory access enable
m_we  out  1  memory write
m_be  out  4  byte enables; bit i selects bits 8i+7:8i
m_addr  out  clog2(DEPTH_WORDS)  word index = addr[...:2]
m_wdata  out  32  lane-replicated write data
m_rdata  in  32  synchronous read data, valid the cycle after m_en & ~m_we

Behaviour:
- Reset: every output 0, starvation counter 0, pending response cleared. A response due the cycle after reset asserts is dropped.
- Grant is combinational, at most one per cycle.
  - C wins by default.
  - D wins when only D requests, or when d_req is high and wait_cnt == MAX_WAIT.
  - c_ready = c_req & grant_c; d_ready = d_req & grant_d.
- wait_cnt:
  - Increments when d_req & ~d_ready, saturating at MAX_WAIT.
  - Clears on d_ready or when d_req is low.
- Error checks. Any one of the following raises the error:
  - sh/lh with addr[0] = 1
  - sw/lw or any D access with addr[1:0] != 0
  - word index >= DEPTH_WORDS
  - illegal c_op
  - c_op loads (1xx) with c_we = 1, or stores (0xx) with c_we = 0
- Erroring request: still accepted (ready = 1), m_en = 0. Next cycle rvalid = 1, err = 1, rdata = 0.
- Byte enables:
  - sw: 1111
  - sh: 0011 << (2*addr[1])
  - sb: 0001 << addr[1:0]
  - D: 1111
- m_wdata:
  - sw/D: data unchanged
  - sh: {w[15:0], w[15:0]}
  - sb: {4{w[7:0]}}
- Response timing: rvalid pulses exactly one cycle after ready for both loads and stores.
- Pending registers capture port, op and addr[1:0].
- Load data is taken from m_rdata in the response cycle:
  - lw: the word
  - lh: sign-extended m_rdata[16*addr[1]+15 -: 16]
  - lb: sign-extended byte addr[1:0]
- Back-to-back accepts every cycle are allowed; no bubbles.
- Simultaneous requests to the same word: only one is granted; the loser sees ready = 0 and is retried by its requester.

Optional Feature:
DM_ARB_TRACE_EN
- Defined: on every accepted, non-error write, print "%d@%h: *%h <= %h" with $time, c_pc (0 for D), word-aligned byte address, and the write data with non-enabled bytes shown as 00.
- Undefined: no display statements; identical cycle behaviour.

Test Plan:
- Reset, then c_req sw addr 0x10 data 0xDEADBEEF -> m_be 1111, m_addr 4, next cycle c_rvalid = 1, c_err = 0; lw 0x10 -> c_rdata 0xDEADBEEF.
- sb 0x13 data 0x80, then lb 0x13 -> m_be 1000, m_wdata 0x80808080; c_rdata 0xFFFFFF80. lh 0x12 after sh 0x12 of 0x7FFF -> 0x00007FFF.
- lw 0x6 and sh 0x5 -> no m_en, c_err = 1, c_rdata 0; word index 3072 -> c_err = 1.
- c_req and d_req held high continuously, MAX_WAIT = 4 -> C granted 4 cycles, D granted on the 5th, counter cleared, pattern repeats; c_stall = 1 in D's cycle.
- Reset asserted the cycle after an accepted lw -> no c_rvalid next cycle, all outputs 0.
- D write 0x40 = 0x12345678 with no C request, then C lb 0x41 -> d_rvalid after 1 cycle; c_rdata 0x00000056.
